forney_syndrome_compute: RTL

- Downstream consumer of the erasure locator polynomial stage.
- Buffers the 2t syndromes S0..S(2t-1) and fetches erasure locator coefficients Gamma0..Gamma(e) through the send_erasure_polyn / erasure_coef_ready handshake.
- Computes the modified (Forney) syndromes T(x) = S(x)*Gamma(x) mod x^(2t) over GF(2^8) and streams them to the errata-locator (Berlekamp-Massey) stage.

---
 rtl/rs_pkg.sv | 26 ++
 rtl/gf_mult_8.sv | 33 +++
 rtl/forney_syndrome_compute.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/rs_pkg.sv
`default_nettype none
// ============================================================================
//  Package   : rs_pkg
//  Purpose   : Shared Reed-Solomon decoder definitions: symbol width, GF(2^8)
//              reduction polynomial and the Forney-syndrome stage state set.
//  Revision  : 1.0  initial release
// ============================================================================
package rs_pkg;

    // Symbol width of the GF(2^8) field
    localparam int SYM_W = 8;

    // Low byte of the field polynomial x^8+x^4+x^3+x^2+1 (0x11D)
    localparam logic [SYM_W-1:0] GF_POLY = 8'h1D;

    // Forney syndrome stage sequencing
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_FETCH = 3'd2,
        ST_OUT   = 3'd3,
        ST_FIN   = 3'd4
    } state_e;

endpackage : rs_pkg
`default_nettype wire

// File: rtl/gf_mult_8.sv
`default_nettype none
// ============================================================================
//  Module    : gf_mult_8
//  Purpose   : Combinational GF(2^8) multiplier, shift-and-add with reduction
//              by the shared field polynomial after every shift.
//  Revision  : 1.0  initial release
// ============================================================================
module gf_mult_8
    import rs_pkg::*;
(
    input  logic [SYM_W-1:0] a_i,
    input  logic [SYM_W-1:0] b_i,
    output logic [SYM_W-1:0] p_o
);

    logic [SYM_W-1:0] w_acc;
    logic [SYM_W-1:0] w_sh;

    // Accumulate a*x^i for every set bit of b, keeping a*x^i reduced
    always_comb begin
        w_acc = '0;
        w_sh  = a_i;
        for (int i = 0; i < SYM_W; i++) begin
            if (b_i[i]) begin
                w_acc = w_acc ^ w_sh;
            end
            w_sh = {w_sh[SYM_W-2:0], 1'b0} ^ (w_sh[SYM_W-1] ? GF_POLY : '0);
        end
        p_o = w_acc;
    end

endmodule : gf_mult_8
`default_nettype wire

// File: rtl/forney_syndrome_compute.sv
`default_nettype none
// ============================================================================
//  Module    : forney_syndrome_compute
//  Purpose   : Buffers 2t syndromes, fetches the erasure locator coefficients
//              and produces T(x) = S(x)*Gamma(x) mod x^(2t) over GF(2^8),
//              streaming T_0..T_(P-1) to the errata-locator stage.
//  Revision  : 1.0  initial release
// ============================================================================
module forney_syndrome_compute
    import rs_pkg::*;
#(
    parameter int WIDTH           = 5,
    parameter int NUMBER_OF_COEFS = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [WIDTH-1:0]  no_of_parity,
    input  logic [WIDTH-1:0]  no_of_erasure_coefs,
    input  logic              synd_valid,
    input  logic [SYM_W-1:0]  synd_in,
    output logic              send_erasure_polyn,
    input  logic              erasure_coef_ready,
    input  logic [SYM_W-1:0]  erasure_loc_polyn,
    output logic              t_valid,
    output logic [SYM_W-1:0]  t_data,
    output logic [WIDTH-1:0]  t_addr,
    output logic              busy,
    output logic              done,
    output logic              erasure_overflow
);

    localparam int               IDX_W   = $clog2(NUMBER_OF_COEFS);
    localparam logic [WIDTH-1:0] C_MAX_P = WIDTH'(NUMBER_OF_COEFS);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] p_q,     p_d;      // clamped 2t
    logic [WIDTH-1:0] e_q,     e_d;      // locator degree
    logic [WIDTH-1:0] idx_q,   idx_d;    // load index, then output index
    logic [WIDTH-1:0] req_q,   req_d;    // coefficient requests issued
    logic [WIDTH-1:0] rcv_q,   rcv_d;    // coefficients received (= j)
    logic             ovf_q,   ovf_d;
    logic [SYM_W-1:0] syn_q [NUMBER_OF_COEFS];
    logic [SYM_W-1:0] syn_d [NUMBER_OF_COEFS];
    logic [SYM_W-1:0] t_q   [NUMBER_OF_COEFS];
    logic [SYM_W-1:0] t_d   [NUMBER_OF_COEFS];

    logic [WIDTH-1:0] w_p_clamp;
    logic             w_tap  [NUMBER_OF_COEFS];
    logic [IDX_W-1:0] w_sidx [NUMBER_OF_COEFS];
    logic [SYM_W-1:0] w_sop  [NUMBER_OF_COEFS];
    logic [SYM_W-1:0] w_prod [NUMBER_OF_COEFS];

    assign w_p_clamp = (no_of_parity > C_MAX_P) ? C_MAX_P : no_of_parity;

    // One multiplier per T position: term Gamma_j * S[k-j] for k in j..P-1
    for (genvar k = 0; k < NUMBER_OF_COEFS; k++) begin : g_mult
        localparam logic [WIDTH-1:0] C_K  = WIDTH'(k);
        localparam logic [IDX_W-1:0] C_KI = IDX_W'(k);

        assign w_tap[k]  = (C_K >= rcv_q) && (C_K < p_q);
        assign w_sidx[k] = C_KI - rcv_q[IDX_W-1:0];
        assign w_sop[k]  = w_tap[k] ? syn_q[w_sidx[k]] : '0;

        gf_mult_8 u_gf_mult (
            .a_i (erasure_loc_polyn),
            .b_i (w_sop[k]),
            .p_o (w_prod[k])
        );
    end

    // State, counters and buffers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            p_q     <= '0;
            e_q     <= '0;
            idx_q   <= '0;
            req_q   <= '0;
            rcv_q   <= '0;
            ovf_q   <= 1'b0;
            for (int i = 0; i < NUMBER_OF_COEFS; i++) begin
                syn_q[i] <= '0;
                t_q[i]   <= '0;
            end
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            e_q     <= e_d;
            idx_q   <= idx_d;
            req_q   <= req_d;
            rcv_q   <= rcv_d;
            ovf_q   <= ovf_d;
            for (int i = 0; i < NUMBER_OF_COEFS; i++) begin
                syn_q[i] <= syn_d[i];
                t_q[i]   <= t_d[i];
            end
        end
    end

    // Next-state, datapath updates and strobes
    always_comb begin
        state_d            = state_q;
        p_d                = p_q;
        e_d                = e_q;
        idx_d              = idx_q;
        req_d              = req_q;
        rcv_d              = rcv_q;
        ovf_d              = ovf_q;
        syn_d              = syn_q;
        t_d                = t_q;
        send_erasure_polyn = 1'b0;
        t_valid            = 1'b0;
        t_data             = '0;
        t_addr             = '0;
        done               = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    p_d   = w_p_clamp;
                    e_d   = no_of_erasure_coefs;
                    idx_d = '0;
                    req_d = '0;
                    rcv_d = '0;
                    ovf_d = 1'b0;
                    for (int i = 0; i < NUMBER_OF_COEFS; i++) begin
                        t_d[i] = '0;
                    end
                    if (no_of_erasure_coefs > w_p_clamp) begin
                        ovf_d   = 1'b1;
                        state_d = ST_FIN;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end

            ST_LOAD: begin
                if (p_q == '0) begin
                    state_d = ST_FETCH;
                end else if (synd_valid) begin
                    syn_d[idx_q[IDX_W-1:0]] = synd_in;
                    idx_d = idx_q + 1'b1;
                    if (idx_q + 1'b1 == p_q) begin
                        idx_d   = '0;
                        state_d = ST_FETCH;
                    end
                end
            end

            ST_FETCH: begin
                // Request exactly E+1 coefficients, back to back
                if (req_q <= e_q) begin
                    send_erasure_polyn = 1'b1;
                    req_d = req_q + 1'b1;
                end
                if (erasure_coef_ready && (rcv_q <= e_q)) begin
                    for (int i = 0; i < NUMBER_OF_COEFS; i++) begin
                        if (w_tap[i]) begin
                            t_d[i] = t_q[i] ^ w_prod[i];
                        end
                    end
                    rcv_d = rcv_q + 1'b1;
                    if (rcv_q == e_q) begin
                        idx_d   = '0;
                        state_d = ST_OUT;
                    end
                end
            end

            ST_OUT: begin
                if (idx_q < p_q) begin
                    t_valid = 1'b1;
                    t_addr  = idx_q;
                    t_data  = t_q[idx_q[IDX_W-1:0]];
                end
                idx_d = idx_q + 1'b1;
                if (idx_q + 1'b1 >= p_q) begin
                    state_d = ST_FIN;
                end
            end

            ST_FIN: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy             = (state_q == ST_LOAD) || (state_q == ST_FETCH) || (state_q == ST_OUT);
    assign erasure_overflow = ovf_q;

endmodule : forney_syndrome_compute
`default_nettype wire
